// File: rtl/cpu_types_pkg.sv
// Shared types and default sizes for the pipeline skid latch.
package cpu_types_pkg;

    localparam int unsigned SKID_WIDTH_DEF = 32;
    localparam int unsigned SKID_CNT_W_DEF = 16;

    // Entry count doubles as the encoding, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [1:0] occ_of_state(skid_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_skid_latch_if.sv
// Handshake and status bundle for the pipeline skid latch.
interface pipe_skid_latch_if #(
    parameter int unsigned WIDTH = cpu_types_pkg::SKID_WIDTH_DEF,
    parameter int unsigned CNT_W = cpu_types_pkg::SKID_CNT_W_DEF
);
    logic             en;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cycles;

    modport sl (
        input  en, flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_cycles
    );

    modport tb (
        output en, flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_cycles
    );
endinterface

// File: rtl/pipe_skid_latch.sv
// Two-entry pipeline skid latch: main holds the head, skid absorbs one
// extra word while downstream stalls; saturating stall-cycle counter.
module pipe_skid_latch
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = SKID_WIDTH_DEF,
    parameter int unsigned CNT_W = SKID_CNT_W_DEF
) (
    input  logic            CLK,
    input  logic            nRST,
    pipe_skid_latch_if.sl   bus
);

    skid_state_t      state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic [CNT_W-1:0] stall_q, stall_nxt;
    logic             in_ready, out_valid;
    logic             accept, emit;

    // State, storage and counter registers with asynchronous clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state   <= state_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
            stall_q <= stall_nxt;
        end
    end

    // Handshake decode, next-state and data movement; flush overrides all.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        stall_nxt = stall_q;

        in_ready  = (state != ST_FULL) && bus.en && !bus.flush;
        out_valid = (state != ST_EMPTY) && bus.en;
        accept    = bus.in_valid && in_ready;
        emit      = out_valid && bus.out_ready;

        // Counter ignores flush: it only watches the visible output stall.
        if (out_valid && !bus.out_ready && (stall_q != '1))
            stall_nxt = stall_q + CNT_W'(1);

        if (bus.flush) begin
            state_nxt = ST_EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        main_nxt  = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && !emit) begin
                        state_nxt = ST_FULL;
                        skid_nxt  = bus.in_data;
                    end else if (emit && !accept) begin
                        state_nxt = ST_EMPTY;
                    end else if (accept && emit) begin
                        main_nxt  = bus.in_data;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        state_nxt = ST_ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = main_q;
    assign bus.occupancy    = occ_of_state(state);
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Self-checking bench for pipe_skid_latch: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pipe_skid_latch;

    localparam int unsigned W   = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned SW  = 8;
    localparam int unsigned SCW = 2;
    localparam int unsigned M_MAX = (1 << CW) - 1;
    localparam int unsigned S_MAX = (1 << SCW) - 1;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    pipe_skid_latch_if #(.WIDTH(W),  .CNT_W(CW))  bus  ();
    pipe_skid_latch_if #(.WIDTH(SW), .CNT_W(SCW)) sbus ();

    pipe_skid_latch #(.WIDTH(W),  .CNT_W(CW))  dut     (.CLK(CLK), .nRST(nRST), .bus(bus));
    pipe_skid_latch #(.WIDTH(SW), .CNT_W(SCW)) dut_sat (.CLK(CLK), .nRST(nRST), .bus(sbus));

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO of held words and a saturating stall count.
    logic [W-1:0]  mq[$];
    logic [SW-1:0] sq[$];
    int unsigned   m_stall = 0;
    int unsigned   s_stall = 0;

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic cycle();
        bit acc, emt;
        @(posedge CLK);
        if (nRST) begin
            acc = bus.in_valid && bus.en && !bus.flush && (mq.size() < 2);
            emt = bus.en && (mq.size() > 0) && bus.out_ready;
            if (bus.en && mq.size() > 0 && !bus.out_ready && m_stall < M_MAX) m_stall++;
            if (bus.flush) mq.delete();
            else begin
                if (emt) void'(mq.pop_front());
                if (acc) mq.push_back(bus.in_data);
            end
            acc = sbus.in_valid && sbus.en && !sbus.flush && (sq.size() < 2);
            emt = sbus.en && (sq.size() > 0) && sbus.out_ready;
            if (sbus.en && sq.size() > 0 && !sbus.out_ready && s_stall < S_MAX) s_stall++;
            if (sbus.flush) sq.delete();
            else begin
                if (emt) void'(sq.pop_front());
                if (acc) sq.push_back(sbus.in_data);
            end
        end
        #1;
    endtask

    task automatic drive(input bit en, input bit fl, input bit v, input logic [W-1:0] d, input bit rdy);
        bus.en = en; bus.flush = fl; bus.in_valid = v; bus.in_data = d; bus.out_ready = rdy;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        sbus.en = 1'b1; sbus.flush = 1'b0; sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.out_ready = 1'b1;
        #12;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_data: got %0h want 0", bus.out_data); end
        total++; if (bus.stall_cycles !== '0) begin bad++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles); end
        @(negedge CLK);
        nRST = 1'b1;
        cycle();
        @(negedge CLK);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        cycle();
    endtask

    task automatic test_stream();
        drive(1'b1, 1'b0, 1'b1, 32'h1, 1'b1);
        cycle();
        for (int i = 2; i <= 4; i++) begin
            if (i <= 3) bus.in_data = W'(i);
            else bus.in_valid = 1'b0;
            @(negedge CLK);
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== W'(i - 1))
                begin bad++; $display("FAIL stream_data: got v=%0b d=%0h want v=1 d=%0h", bus.out_valid, bus.out_data, i - 1); end
            total++; if (bus.occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ: got %0d want 1", bus.occupancy); end
            cycle();
        end
        @(negedge CLK);
        total++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0)
            begin bad++; $display("FAIL stream_drain: got v=%0b occ=%0d want v=0 occ=0", bus.out_valid, bus.occupancy); end
        cycle();
    endtask

    task automatic test_backpressure();
        int unsigned base;
        base = m_stall;
        drive(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        cycle();
        bus.in_data = 32'hB;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        bus.out_ready = 1'b1;
        @(negedge CLK);
        total++; if (bus.occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ: got %0d want 2", bus.occupancy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0", bus.in_ready); end
        total++; if (bus.stall_cycles !== CW'(base + 2)) begin bad++; $display("FAIL bp_stall: got %0d want %0d", bus.stall_cycles, base + 2); end
        total++; if (bus.out_data !== 32'hA) begin bad++; $display("FAIL bp_first: got %0h want a", bus.out_data); end
        cycle();
        @(negedge CLK);
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hB)
            begin bad++; $display("FAIL bp_second: got v=%0b d=%0h want v=1 d=b", bus.out_valid, bus.out_data); end
        cycle();
        @(negedge CLK);
        total++; if (bus.out_valid !== 1'b0 || bus.stall_cycles !== CW'(base + 2))
            begin bad++; $display("FAIL bp_drain: got v=%0b stall=%0d want v=0 stall=%0d", bus.out_valid, bus.stall_cycles, base + 2); end
        cycle();
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        cycle();
        bus.in_data = 32'hB;
        cycle();
        drive(1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
        @(negedge CLK);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %0b want 0", bus.in_ready); end
        cycle();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(negedge CLK);
        total++; if (bus.occupancy !== 2'd0 || bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL flush_empty: got occ=%0d v=%0b want occ=0 v=0", bus.occupancy, bus.out_valid); end
        total++; if (bus.out_data !== '0) begin bad++; $display("FAIL flush_zero: got %0h want 0", bus.out_data); end
        total++; if (bus.stall_cycles !== CW'(m_stall)) begin bad++; $display("FAIL flush_stall: got %0d want %0d", bus.stall_cycles, m_stall); end
        cycle();
    endtask

    task automatic test_enable();
        int unsigned base;
        drive(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
        cycle();
        base = m_stall;
        drive(1'b0, 1'b0, 1'b1, 32'h9, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.occupancy !== 2'd1)
                begin bad++; $display("FAIL en_hold: got v=%0b r=%0b occ=%0d want 0 0 1", bus.out_valid, bus.in_ready, bus.occupancy); end
            total++; if (bus.stall_cycles !== CW'(base)) begin bad++; $display("FAIL en_stall: got %0d want %0d", bus.stall_cycles, base); end
            cycle();
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        @(negedge CLK);
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5)
            begin bad++; $display("FAIL en_emit: got v=%0b d=%0h want v=1 d=5", bus.out_valid, bus.out_data); end
        cycle();
        @(negedge CLK);
        total++; if (bus.occupancy !== 2'd0) begin bad++; $display("FAIL en_drain: got %0d want 0", bus.occupancy); end
        cycle();
    endtask

    task automatic test_saturate();
        sbus.en = 1'b1; sbus.flush = 1'b0; sbus.in_valid = 1'b1; sbus.in_data = 8'h5A; sbus.out_ready = 1'b0;
        cycle();
        sbus.in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            @(negedge CLK);
            total++; if (sbus.stall_cycles !== SCW'((k < 3) ? k : 3))
                begin bad++; $display("FAIL sat_count: got %0d want %0d", sbus.stall_cycles, (k < 3) ? k : 3); end
            total++; if (sbus.stall_cycles !== SCW'(s_stall))
                begin bad++; $display("FAIL sat_model: got %0d want %0d", sbus.stall_cycles, s_stall); end
        end
        sbus.out_ready = 1'b1;
        cycle();
        @(negedge CLK);
        total++; if (sbus.out_valid !== 1'b0) begin bad++; $display("FAIL sat_drain: got %0b want 0", sbus.out_valid); end
        cycle();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
        cycle();
        bus.in_data = 32'hB;
        cycle();
        bus.in_valid = 1'b0;
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0)
            begin bad++; $display("FAIL arst_state: got v=%0b occ=%0d want 0 0", bus.out_valid, bus.occupancy); end
        total++; if (bus.out_data !== '0 || bus.stall_cycles !== '0)
            begin bad++; $display("FAIL arst_zero: got d=%0h stall=%0d want 0 0", bus.out_data, bus.stall_cycles); end
        mq.delete(); sq.delete(); m_stall = 0; s_stall = 0;
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle();
        @(negedge CLK);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready: got %0b want 1", bus.in_ready); end
        drive(1'b1, 1'b0, 1'b1, 32'h7, 1'b1);
        cycle();
        bus.in_valid = 1'b0;
        @(negedge CLK);
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h7 || bus.occupancy !== 2'd1)
            begin bad++; $display("FAIL arst_first: got v=%0b d=%0h occ=%0d want 1 7 1", bus.out_valid, bus.out_data, bus.occupancy); end
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 6));
            @(negedge CLK);
            total++; if (bus.out_valid !== (bus.en && mq.size() > 0))
                begin bad++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", n, bus.out_valid, bus.en && mq.size() > 0); end
            total++; if (bus.in_ready !== (bus.en && !bus.flush && mq.size() < 2))
                begin bad++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", n, bus.in_ready, bus.en && !bus.flush && mq.size() < 2); end
            total++; if (bus.occupancy !== 2'(mq.size()))
                begin bad++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", n, bus.occupancy, mq.size()); end
            total++; if (bus.stall_cycles !== CW'(m_stall))
                begin bad++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, bus.stall_cycles, m_stall); end
            if (mq.size() > 0) begin
                total++; if (bus.out_data !== mq[0])
                    begin bad++; $display("FAIL rnd_data[%0d]: got %0h want %0h", n, bus.out_data, mq[0]); end
            end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_enable();
        test_saturate();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1);
    end

endmodule
